spi_slave: RTL and testbench

- Byte-oriented SPI slave (mode 0, MSB first) with a parallel register-style host port.
- Oversamples the external SCK/CS/MOSI lines in the i_clk domain.
- Presents each received byte with a ready flag, and accepts one byte to shift out on MISO during the next byte slot.
- Sits between the external SPI pins and the VGA command controller FSM.

---
 rtl/spi_slave.sv | 139 +++++++++++++
 tb/tb_spi_slave.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: byte-oriented SPI slave (mode 0, MSB first) behind a register-style host port.
// Latency: o_rx_ready rises SYNC_STAGES+1 i_clk cycles after the 8th SCK rising edge.
// Backpressure: o_tx_ready=0 rejects writes (sticky o_tx_error); unread rx byte is overwritten (sticky o_rx_error).
//
// Ports:
//   i_clk, i_rst_n                     system clock, async active-low reset
//   i_cs, i_we, i_re, i_data, o_data   host strobes and data bytes
//   o_rx_ready, o_rx_error             received byte waiting / overrun seen
//   o_tx_ready, o_tx_error             tx slot free / write rejected
//   i_spi_sck, i_spi_cs_l, i_spi_mosi  external SPI pins (asynchronous)
//   o_spi_miso                         slave-out data
module spi_slave #(
  parameter int SYNC_STAGES = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cs,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  input  logic       i_we,
  input  logic       i_re,
  output logic       o_rx_error,
  output logic       o_rx_ready,
  output logic       o_tx_error,
  output logic       o_tx_ready,
  input  logic       i_spi_sck,
  input  logic       i_spi_cs_l,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso
);

  // Synchronizer chains; index SYNC_STAGES-1 is the oldest (fully synchronized) stage.
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] csl_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  // Previous value of the synchronized SCK, used as the reference for edge detection.
  logic                   sck_prev;

  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [2:0] bit_cnt;
  logic       tx_queued;

  logic       sck_s;
  logic       cs_act;
  logic       mosi_s;
  logic       sck_rise;
  logic       sck_fall;
  logic       host_wr;
  logic       host_rd;
  logic [7:0] rx_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_sync  <= '0;
      csl_sync  <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      csl_sync  <= {csl_sync[SYNC_STAGES-2:0], i_spi_cs_l};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_act   = ~csl_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign host_wr  = i_cs & i_we;
  assign host_rd  = i_cs & i_re;
  assign rx_next  = {rx_shift[6:0], mosi_s};

  // A write is only accepted on a byte boundary with nothing already waiting.
  assign o_tx_ready = (bit_cnt == 3'd0) & ~tx_queued;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data     <= 8'h00;
      rx_shift   <= 8'h00;
      tx_shift   <= 8'h00;
      bit_cnt    <= 3'd0;
      tx_queued  <= 1'b0;
      o_rx_ready <= 1'b0;
      o_rx_error <= 1'b0;
      o_tx_error <= 1'b0;
      o_spi_miso <= 1'b0;
    end else begin
      o_spi_miso <= cs_act & tx_shift[7];

      // Acknowledge first so a byte completing in the same cycle overrides it.
      if (host_rd) begin
        o_rx_ready <= 1'b0;
        o_rx_error <= 1'b0;
      end

      if (!cs_act) begin
        // Deselected: realign to a byte boundary and drop any pending tx byte.
        // Host writes while deselected are discarded along with the queue.
        bit_cnt    <= 3'd0;
        o_rx_ready <= 1'b0;
        tx_queued  <= 1'b0;
        tx_shift   <= 8'h00;
        o_tx_error <= 1'b0;
      end else begin
        if (host_wr) begin
          if (o_tx_ready) begin
            tx_shift  <= i_data;
            tx_queued <= 1'b1;
          end else begin
            o_tx_error <= 1'b1;
          end
        end

        if (sck_rise) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            o_data     <= rx_next;
            o_rx_ready <= 1'b1;
            if (o_rx_ready) begin
              o_rx_error <= 1'b1;
            end
            // Byte slot consumed: the remaining bit must not leak into the next byte.
            tx_queued <= 1'b0;
            tx_shift  <= 8'h00;
          end
        end else if (sck_fall && bit_cnt != 3'd0) begin
          // The falling edge that trails the 8th rising edge is skipped so a byte
          // written between bytes is not shifted before its MSB is sampled.
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  localparam int SYNC_STAGES = 3;
  localparam int HALF        = 8;   // SCK half-period in i_clk cycles

  logic       i_clk      = 1'b0;
  logic       i_rst_n    = 1'b0;
  logic       i_cs       = 1'b0;
  logic [7:0] i_data     = 8'h00;
  logic       i_we       = 1'b0;
  logic       i_re       = 1'b0;
  logic       i_spi_sck  = 1'b0;
  logic       i_spi_cs_l = 1'b1;
  logic       i_spi_mosi = 1'b0;
  logic [7:0] o_data;
  logic       o_rx_error;
  logic       o_rx_ready;
  logic       o_tx_error;
  logic       o_tx_ready;
  logic       o_spi_miso;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: host-visible state at byte boundaries.
  logic [7:0] m_data  = 8'h00;
  bit         m_rdy   = 1'b0;
  bit         m_rxerr = 1'b0;
  bit         m_txerr = 1'b0;
  bit         m_has_q = 1'b0;
  logic [7:0] m_q     = 8'h00;

  logic [7:0] miso_acc;
  int         lat;

  spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_cs       (i_cs),
    .i_data     (i_data),
    .o_data     (o_data),
    .i_we       (i_we),
    .i_re       (i_re),
    .o_rx_error (o_rx_error),
    .o_rx_ready (o_rx_ready),
    .o_tx_error (o_tx_error),
    .o_tx_ready (o_tx_ready),
    .i_spi_sck  (i_spi_sck),
    .i_spi_cs_l (i_spi_cs_l),
    .i_spi_mosi (i_spi_mosi),
    .o_spi_miso (o_spi_miso)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check8({tag, "_data"},   o_data,     m_data);
    check1({tag, "_rxrdy"},  o_rx_ready, m_rdy);
    check1({tag, "_rxerr"},  o_rx_error, m_rxerr);
    check1({tag, "_txerr"},  o_tx_error, m_txerr);
    check1({tag, "_txrdy"},  o_tx_ready, !m_has_q);
  endtask

  // Master clocks bits hi..lo of mo (mode 0), capturing MISO before each rising edge.
  task automatic spi_bits(input logic [7:0] mo, input int hi, input int lo);
    for (int b = hi; b >= lo; b--) begin
      i_spi_mosi = mo[b];
      tick(HALF);
      miso_acc = {miso_acc[6:0], o_spi_miso};
      i_spi_sck = 1'b1;
      lat = -1;
      for (int k = 1; k <= HALF; k++) begin
        tick(1);
        if (lat < 0 && o_rx_ready) lat = k;
      end
      i_spi_sck = 1'b0;
    end
  endtask

  task automatic model_byte(input logic [7:0] mo, output logic [7:0] exp_mi);
    exp_mi  = m_has_q ? m_q : 8'h00;
    m_has_q = 1'b0;
    if (m_rdy) m_rxerr = 1'b1;
    m_rdy  = 1'b1;
    m_data = mo;
  endtask

  task automatic send_byte(input logic [7:0] mo, input string tag);
    logic [7:0] exp_mi;
    bit         was_rdy;
    was_rdy  = o_rx_ready;
    miso_acc = 8'h00;
    spi_bits(mo, 7, 0);
    model_byte(mo, exp_mi);
    tick(4);
    check_all(tag);
    check8({tag, "_miso"}, miso_acc, exp_mi);
    if (!was_rdy) check8({tag, "_lat"}, 8'(lat), 8'(SYNC_STAGES + 1));
  endtask

  task automatic write_raw(input logic [7:0] d);
    i_cs = 1'b1; i_we = 1'b1; i_data = d;
    tick(1);
    i_cs = 1'b0; i_we = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] d);
    write_raw(d);
    if (m_has_q) m_txerr = 1'b1;
    else begin
      m_has_q = 1'b1;
      m_q     = d;
    end
  endtask

  task automatic host_read();
    i_cs = 1'b1; i_re = 1'b1;
    tick(1);
    i_cs = 1'b0; i_re = 1'b0;
    m_rdy   = 1'b0;
    m_rxerr = 1'b0;
  endtask

  task automatic cs_pulse(input string tag);
    i_spi_cs_l = 1'b1;
    tick(8);
    m_rdy   = 1'b0;
    m_has_q = 1'b0;
    m_txerr = 1'b0;
    check_all(tag);
    i_spi_cs_l = 1'b0;
    tick(8);
  endtask

  initial begin
    logic [7:0] d;
    bit         acc;
    int         r;

    // Reset state
    tick(3);
    check_all("reset");
    check1("reset_miso", o_spi_miso, 1'b0);
    i_rst_n = 1'b1;
    tick(2);
    i_spi_cs_l = 1'b0;
    tick(8);
    check_all("idle");

    // Queue a byte: tx_ready drops at once, MISO shows the MSB one cycle later
    host_write(8'hC3);
    check1("wr_txrdy", o_tx_ready, 1'b0);
    check1("wr_miso0", o_spi_miso, 1'b0);
    tick(1);
    check1("wr_miso1", o_spi_miso, 1'b1);

    // Two bytes with reads in between
    send_byte(8'h81, "b81");
    host_read();
    check_all("rd81");
    send_byte(8'hA5, "bA5");
    host_read();
    check_all("rdA5");

    // Overrun
    send_byte(8'h12, "b12");
    send_byte(8'h34, "b34");
    host_read();
    check_all("rd_ovr");

    // Read flow: command, dummy, then reply byte
    send_byte(8'h04, "cmd");
    host_read();
    send_byte(8'h00, "dummy");
    host_write(8'h5C);
    host_read();
    check_all("wr5C");
    send_byte(8'hFF, "reply");
    host_read();

    // Write during an active byte
    miso_acc = 8'h00;
    spi_bits(8'h3C, 7, 4);
    write_raw(8'h77);
    m_txerr = 1'b1;
    check1("mid_txerr", o_tx_error, 1'b1);
    check1("mid_txrdy", o_tx_ready, 1'b0);
    spi_bits(8'h3C, 3, 0);
    model_byte(8'h3C, d);
    tick(4);
    check_all("mid_done");
    check8("mid_miso", miso_acc, d);
    cs_pulse("csh");

    // Reset in the middle of a byte with a tx byte queued
    host_write(8'hFF);
    spi_bits(8'h96, 7, 4);
    i_rst_n = 1'b0;
    tick(2);
    m_data = 8'h00; m_rdy = 1'b0; m_rxerr = 1'b0; m_txerr = 1'b0; m_has_q = 1'b0;
    check_all("rst_mid");
    check1("rst_mid_miso", o_spi_miso, 1'b0);
    i_rst_n = 1'b1;
    tick(8);
    send_byte(8'h6B, "post_rst");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        send_byte(8'($urandom), "rnd_byte");
      end else if (r <= 5) begin
        host_read();
        check_all("rnd_read");
      end else if (r <= 7) begin
        acc = !m_has_q;
        d   = 8'($urandom);
        host_write(d);
        if (acc) begin
          tick(1);
          check1("rnd_miso_msb", o_spi_miso, d[7]);
        end
        check_all("rnd_write");
      end else begin
        cs_pulse("rnd_cs");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
